// File: rtl/trng_key_fifo.sv
// Key buffer between the TRNG core and the bus reader: one capture per key_ready
// assertion, DEPTH-entry show-ahead FIFO, sticky failure flag and fill-level interrupt.
module trng_key_fifo #(
   parameter int unsigned N_BITS_KEY = 32,
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned IRQ_LEVEL  = 2
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         enable_i,
   input  logic                         key_ready_i,
   input  logic [N_BITS_KEY-1:0]        key_i,
   input  logic                         fail_i,
   output logic                         ack_read_o,
   output logic                         rd_valid_o,
   input  logic                         rd_ready_i,
   output logic [N_BITS_KEY-1:0]        rd_data_o,
   output logic [$clog2(DEPTH+1)-1:0]   level_o,
   output logic                         full_o,
   output logic                         empty_o,
   output logic                         fail_o,
   output logic                         irq_o
);

   localparam int unsigned LW = $clog2(DEPTH + 1);
   localparam int unsigned PW = $clog2(DEPTH);

   typedef enum logic {
      WAIT_KEY,
      WAIT_DROP
   } state_t;

   state_t                  state;
   logic [N_BITS_KEY-1:0]   mem [DEPTH];
   logic [PW-1:0]           wr_ptr;
   logic [PW-1:0]           rd_ptr;
   logic [LW-1:0]           level;
   logic                    fail_q;
   logic                    ack_q;
   logic                    irq_q;
   logic                    flush;
   logic                    push;
   logic                    pop;

   assign full_o     = (level == LW'(DEPTH));
   assign empty_o    = (level == '0);
   assign rd_valid_o = ~empty_o;
   assign rd_data_o  = mem[rd_ptr];
   assign level_o    = level;
   assign fail_o     = fail_q;
   assign ack_read_o = ack_q;
   assign irq_o      = irq_q;

   // Push uses the registered full flag, so a pop in the same cycle never lets a key in early.
   always_comb begin
      flush = ~enable_i | fail_i;
      push  = 1'b0;
      pop   = 1'b0;
      if (!flush && !fail_q) begin
         push = key_ready_i & (state == WAIT_KEY) & ~full_o;
         pop  = rd_ready_i & ~empty_o;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (push) begin
         mem[wr_ptr] <= key_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state  <= WAIT_KEY;
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         fail_q <= 1'b0;
         ack_q  <= 1'b0;
         irq_q  <= 1'b0;
      end else if (flush) begin
         // Disable clears the failure flag; a failure while enabled sets it.
         state  <= WAIT_KEY;
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         fail_q <= enable_i;
         ack_q  <= 1'b0;
         irq_q  <= 1'b0;
      end else begin
         ack_q <= push;
         irq_q <= push & ~pop & (level == LW'(IRQ_LEVEL - 1));
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         if (push && !pop) begin
            level <= level + LW'(1);
         end else if (pop && !push) begin
            level <= level - LW'(1);
         end
         case (state)
            WAIT_KEY: begin
               if (push) begin
                  state <= WAIT_DROP;
               end
            end
            WAIT_DROP: begin
               if (!key_ready_i) begin
                  state <= WAIT_KEY;
               end
            end
            default: state <= WAIT_KEY;
         endcase
      end
   end

endmodule

// File: tb/tb_trng_key_fifo.sv
// Directed and random checks of trng_key_fifo against a queue-based reference model.
module tb_trng_key_fifo;

   localparam int unsigned N  = 32;
   localparam int unsigned DP = 4;
   localparam int unsigned IL = 2;

   logic          clk = 1'b0;
   logic          rst_ni;
   logic          enable_i;
   logic          key_ready_i;
   logic [N-1:0]  key_i;
   logic          fail_i;
   logic          ack_read_o;
   logic          rd_valid_o;
   logic          rd_ready_i;
   logic [N-1:0]  rd_data_o;
   logic [2:0]    level_o;
   logic          full_o;
   logic          empty_o;
   logic          fail_o;
   logic          irq_o;

   int total = 0;
   int bad   = 0;

   // Reference model state
   logic [N-1:0] q[$];
   bit           m_fail;
   bit           m_armed;
   bit           m_ack;
   bit           m_irq;

   trng_key_fifo #(.N_BITS_KEY(N), .DEPTH(DP), .IRQ_LEVEL(IL)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_ni),
      .enable_i    (enable_i),
      .key_ready_i (key_ready_i),
      .key_i       (key_i),
      .fail_i      (fail_i),
      .ack_read_o  (ack_read_o),
      .rd_valid_o  (rd_valid_o),
      .rd_ready_i  (rd_ready_i),
      .rd_data_o   (rd_data_o),
      .level_o     (level_o),
      .full_o      (full_o),
      .empty_o     (empty_o),
      .fail_o      (fail_o),
      .irq_o       (irq_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_fail  = 1'b0;
      m_armed = 1'b1;
      m_ack   = 1'b0;
      m_irq   = 1'b0;
   endtask

   // Advance the model by one clock using the inputs currently applied.
   task automatic model_step();
      int unsigned old_n;
      bit do_push;
      bit do_pop;
      if (!enable_i || fail_i) begin
         q.delete();
         m_fail  = enable_i;
         m_armed = 1'b1;
         m_ack   = 1'b0;
         m_irq   = 1'b0;
      end else begin
         old_n   = q.size();
         do_push = m_armed && key_ready_i && (old_n < DP) && !m_fail;
         do_pop  = (old_n > 0) && rd_ready_i && !m_fail;
         if (do_pop) void'(q.pop_front());
         if (do_push) q.push_back(key_i);
         m_ack = do_push;
         m_irq = do_push && (q.size() == IL) && (old_n != IL);
         if (do_push) m_armed = 1'b0;
         else if (!key_ready_i) m_armed = 1'b1;
      end
   endtask

   task automatic check_all();
      chk("ack", 64'(ack_read_o), 64'(m_ack));
      chk("irq", 64'(irq_o), 64'(m_irq));
      chk("level", 64'(level_o), 64'(q.size()));
      chk("empty", 64'(empty_o), 64'(q.size() == 0));
      chk("full", 64'(full_o), 64'(q.size() == DP));
      chk("valid", 64'(rd_valid_o), 64'(q.size() != 0));
      chk("fail", 64'(fail_o), 64'(m_fail));
      if (q.size() != 0) chk("data", 64'(rd_data_o), 64'(q[0]));
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic push_key(input logic [N-1:0] k);
      key_i       = k;
      key_ready_i = 1'b1;
      tick();
      key_ready_i = 1'b0;
      tick();
   endtask

   task automatic drain();
      key_ready_i = 1'b0;
      rd_ready_i  = 1'b1;
      for (int i = 0; i < 8; i++) tick();
      rd_ready_i  = 1'b0;
      chk("drain_empty", 64'(empty_o), 64'(1));
   endtask

   task automatic check_reset_values();
      chk("rst_ack", 64'(ack_read_o), 64'(0));
      chk("rst_valid", 64'(rd_valid_o), 64'(0));
      chk("rst_data", 64'(rd_data_o), 64'(0));
      chk("rst_level", 64'(level_o), 64'(0));
      chk("rst_full", 64'(full_o), 64'(0));
      chk("rst_empty", 64'(empty_o), 64'(1));
      chk("rst_fail", 64'(fail_o), 64'(0));
      chk("rst_irq", 64'(irq_o), 64'(0));
   endtask

   initial begin
      int acks;
      rst_ni      = 1'b0;
      enable_i    = 1'b1;
      key_ready_i = 1'b0;
      key_i       = '0;
      fail_i      = 1'b0;
      rd_ready_i  = 1'b0;
      model_reset();
      #12;
      check_reset_values();
      @(negedge clk);
      rst_ni = 1'b1;

      // Single key
      key_i       = 32'hDEADBEEF;
      key_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (m_ack) break;
      end
      chk("single_ack", 64'(ack_read_o), 64'(1));
      key_ready_i = 1'b0;
      tick();
      chk("single_ack_once", 64'(ack_read_o), 64'(0));
      chk("single_level", 64'(level_o), 64'(1));
      chk("single_data", 64'(rd_data_o), 64'(32'hDEADBEEF));
      rd_ready_i = 1'b1;
      tick();
      chk("single_empty", 64'(empty_o), 64'(1));
      rd_ready_i = 1'b0;

      // Fill to full with a fifth key pending
      for (int k = 1; k <= 4; k++) push_key(N'(k));
      key_i       = 32'h5;
      key_ready_i = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      chk("fill_full", 64'(full_o), 64'(1));
      chk("fill_no_ack", 64'(ack_read_o), 64'(0));
      chk("fill_head", 64'(rd_data_o), 64'(1));
      rd_ready_i = 1'b1;
      tick();
      rd_ready_i = 1'b0;
      tick();
      chk("fill_ack5", 64'(ack_read_o), 64'(1));
      key_ready_i = 1'b0;
      tick();
      rd_ready_i = 1'b1;
      for (int k = 2; k <= 5; k++) begin
         chk("fill_order", 64'(rd_data_o), 64'(k));
         tick();
      end
      chk("fill_drained", 64'(empty_o), 64'(1));
      rd_ready_i = 1'b0;

      // Held key_ready
      acks        = 0;
      key_i       = 32'hA5A5_0001;
      key_ready_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (ack_read_o) acks++;
      end
      chk("held_acks", 64'(acks), 64'(1));
      chk("held_level", 64'(level_o), 64'(1));
      drain();

      // Simultaneous push and pop at level 2, pointers wrap
      push_key(32'h100);
      push_key(32'h101);
      for (int i = 0; i < 10; i++) begin
         key_i       = N'(32'h200 + i);
         key_ready_i = 1'b1;
         rd_ready_i  = 1'b1;
         tick();
         chk("pp_level", 64'(level_o), 64'(2));
         key_ready_i = 1'b0;
         rd_ready_i  = 1'b0;
         tick();
      end
      chk("pp_head", 64'(rd_data_o), 64'(32'h208));
      drain();

      // Interrupt
      key_i = 32'h11; key_ready_i = 1'b1; tick();
      chk("irq_first", 64'(irq_o), 64'(0));
      key_ready_i = 1'b0; tick();
      key_i = 32'h12; key_ready_i = 1'b1; tick();
      chk("irq_second", 64'(irq_o), 64'(1));
      key_ready_i = 1'b0; tick();
      chk("irq_pulse", 64'(irq_o), 64'(0));
      rd_ready_i = 1'b1; tick();
      chk("irq_pop", 64'(irq_o), 64'(0));
      rd_ready_i = 1'b0;
      key_i = 32'h13; key_ready_i = 1'b1; tick();
      chk("irq_repush", 64'(irq_o), 64'(1));
      key_ready_i = 1'b0; tick();
      enable_i = 1'b0; tick();
      chk("irq_flush", 64'(irq_o), 64'(0));
      enable_i = 1'b1; tick();

      // Failure and disable
      for (int k = 0; k < 3; k++) push_key(N'(32'h300 + k));
      chk("fail_pre_level", 64'(level_o), 64'(3));
      fail_i = 1'b1; tick();
      fail_i = 1'b0;
      chk("fail_level", 64'(level_o), 64'(0));
      chk("fail_flag", 64'(fail_o), 64'(1));
      chk("fail_empty", 64'(empty_o), 64'(1));
      acks        = 0;
      key_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (ack_read_o) acks++;
      end
      chk("fail_acks", 64'(acks), 64'(0));
      key_ready_i = 1'b0; tick();
      enable_i = 1'b0; tick();
      enable_i = 1'b1;
      chk("fail_cleared", 64'(fail_o), 64'(0));
      tick();

      // Reset mid-fill
      push_key(32'hC0DE0001);
      push_key(32'hC0DE0002);
      #2;
      rst_ni = 1'b0;
      #1;
      model_reset();
      check_reset_values();
      @(negedge clk);
      rst_ni = 1'b1;

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         enable_i    = ($urandom_range(0, 24) != 0);
         fail_i      = ($urandom_range(0, 59) == 0);
         key_ready_i = ($urandom_range(0, 1) == 1);
         key_i       = $urandom;
         rd_ready_i  = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
